chacha_mem_block_master: RTL and testbench
==========================================

// Module: chacha_mem_block_master
// PURPOSE
//  Avalon-MM master (initiator) for the single-port data memory, which is the responder.
//  Reads 16-word ChaCha20 blocks from a source region and streams them to the cipher core.
//  Accepts the core's 16-word result stream and writes it to a destination region.
//  Repeats for a commanded number of blocks. Sits between the data memory and the ChaCha core.
// PARAMETERS
//  ADDR_W       14   word-address width, matching the 16384-word memory
//  DATA_W       32   data width in bits; byteenable width is DATA_W/8
//  BLOCK_WORDS  16   words per ChaCha block
// PORTS
//  clk              in   1        system clock
//  reset_n          in   1        asynchronous active-low reset
//  cmd_start        in   1        1-cycle start pulse; sampled only in IDLE
//  cmd_src          in   ADDR_W   source word address
//  cmd_dst          in   ADDR_W   destination word address
//  cmd_blocks       in   8        number of blocks to process; 0 means no blocks
//  busy             out  1        high from start acceptance until DONE exits
//  done             out  1        1-cycle pulse on completion
//  avm_address      out  ADDR_W   word address
//  avm_chipselect   out  1        high whenever avm_read or avm_write is high
//  avm_read         out  1        read request
//  avm_write        out  1        write request
//  avm_writedata    out  DATA_W   write data
//  avm_byteenable   out  DATA_W/8 all ones on every access
//  avm_debugaccess  out  1        equals avm_write; the memory gates writes on it
//  avm_readdata     in   DATA_W   read data, valid exactly 1 cycle after read acceptance
//  avm_waitrequest  in   1        responder stall
//  src_data         out  DATA_W   word to the core
//  src_valid        out  1        src_data is valid
//  src_ready        in   1        core accepts src_data
//  snk_data         in   DATA_W   result word from the core
//  snk_valid        in   1        snk_data is valid
//  snk_ready        out  1        this block accepts snk_data
// BEHAVIOUR
//  Reset values: all outputs 0 (address, data, strobes, valid, ready, busy, done); state=IDLE.
//  Transfer rules:
//   - An access is accepted on a cycle with request high and avm_waitrequest low.
//   - Address, writedata and strobes hold stable while avm_waitrequest is high.
//   - At most one access is outstanding; read and write are never high together.
//  State machine:
//   IDLE: on cmd_start:
//    - cmd_blocks=0 -> DONE.
//    - Otherwise latch src/dst/count, zero word_cnt, busy=1 -> RD_REQ.
//   RD_REQ: avm_read=1, address=src_ptr. On acceptance -> RD_CAP.
//   RD_CAP: capture avm_readdata into src_data, src_valid=1, src_ptr+1 -> RD_HOLD.
//   RD_HOLD: hold src_data until src_valid&src_ready. Then word_cnt+1:
//    - word_cnt = BLOCK_WORDS-1 -> word_cnt=0, WR_IN.
//    - Otherwise -> RD_REQ.
//   WR_IN: snk_ready=1. On snk_valid, latch snk_data into avm_writedata -> WR_REQ.
//    - snk_ready is low in every other state.
//   WR_REQ: avm_write=1, avm_debugaccess=1, address=dst_ptr. On acceptance dst_ptr+1, word_cnt+1:
//    - Last word of last block -> DONE.
//    - Last word of block -> blocks-1, word_cnt=0, RD_REQ.
//    - Otherwise -> WR_IN.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Throughput: best case 3 cycles per read word and 2 cycles per written word.
//  Boundary conditions:
//   - Pointers wrap modulo 2^ADDR_W (e.g. 3FFF+1 -> 0000).
//   - Overlapping src/dst is legal: each block is fully read before it is written.
//   - cmd_start outside IDLE is ignored.
//   - src_valid and src_data are not withdrawn or changed until accepted.
//   - reset_n low mid-transfer aborts immediately to reset values.
//     A pending write is dropped; no done pulse is issued.
// TESTING
//  1. src=0x0100, dst=0x0200, blocks=1, no stalls, core=XOR 0xA5A5A5A5:
//     -> 16 reads 0x100..0x10F, then 16 writes 0x200..0x20F; done after 16*3+16*2+1 cycles.
//  2. avm_waitrequest held high 3 cycles on every 4th access:
//     -> address/strobes stable during the stall; data identical to test 1.
//  3. src_ready low 5 cycles on word 7; snk_valid low 4 cycles on word 3:
//     -> src_data held unchanged; no write issued until the word arrives.
//  4. src=0x3FF8, dst=0x3FF0, blocks=2:
//     -> reads 3FF8..3FFF then 0000..0017; writes 3FF0..3FFF then 0000..000F; 32 writes total.
//  5. blocks=0 -> done pulse 1 cycle after start, no avm_read or avm_write ever asserted.
//  6. reset_n low during WR_REQ of word 5:
//     -> all outputs 0 asynchronously; after release a new start runs test 1 cleanly.

Source files
------------

// File: rtl/chacha_mem_block_master.sv
// ---------------------------------------------------------------------------
// chacha_mem_block_master
//
// Avalon-MM initiator that moves ChaCha20 blocks between the single-port data
// memory and the cipher core. For every block it reads BLOCK_WORDS words from
// the source region and hands them one at a time to the core over a
// valid/ready stream. It then takes BLOCK_WORDS result words back from the
// core and writes them to the destination region. It repeats this for the
// commanded number of blocks and finishes with a one-cycle done pulse.
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   cmd_start            start pulse, only looked at while idle
//   cmd_src / cmd_dst    source / destination word addresses
//   cmd_blocks           number of blocks to process (0 = none)
//   busy, done           status: busy while a command runs, done pulses at end
//   avm_*                Avalon-MM initiator port to the data memory
//   src_data/valid/ready words streamed to the core (this block drives valid)
//   snk_data/valid/ready result words from the core (this block drives ready)
//
// Every output is a register. Each memory request is raised on the cycle
// after the decision to issue it, and it stays frozen until the responder
// drops avm_waitrequest. Only one access is ever in flight.
// ---------------------------------------------------------------------------
module chacha_mem_block_master #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  // command / status
  input  logic                cmd_start,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [7:0]          cmd_blocks,
  output logic                busy,
  output logic                done,
  // Avalon-MM initiator
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_debugaccess,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  // stream to the core
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  // stream from the core
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  output logic                snk_ready
);

  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_CAP,
    S_RD_HOLD,
    S_WR_IN,
    S_WR_REQ,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] src_ptr_reg;
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic [7:0]        blocks_reg;    // blocks still to finish, including the current one
  logic [CNT_W-1:0]  word_cnt_reg;  // word index inside the current block

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      src_ptr_reg     <= '0;
      dst_ptr_reg     <= '0;
      blocks_reg      <= '0;
      word_cnt_reg    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      avm_address     <= '0;
      avm_chipselect  <= 1'b0;
      avm_read        <= 1'b0;
      avm_write       <= 1'b0;
      avm_writedata   <= '0;
      avm_byteenable  <= '0;
      avm_debugaccess <= 1'b0;
      src_data        <= '0;
      src_valid       <= 1'b0;
      snk_ready       <= 1'b0;
    end else begin
      // done is a pulse. It is set only when entering S_DONE and is cleared
      // here on every other cycle.
      done <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_blocks == 8'd0) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              src_ptr_reg    <= cmd_src;
              dst_ptr_reg    <= cmd_dst;
              blocks_reg     <= cmd_blocks;
              word_cnt_reg   <= '0;
              busy           <= 1'b1;
              avm_address    <= cmd_src;
              avm_read       <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_byteenable <= '1;
              state_reg      <= S_RD_REQ;
            end
          end
        end

        // The read request is held until the responder accepts it.
        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_byteenable <= '0;
            state_reg      <= S_RD_CAP;
          end
        end

        // avm_readdata is valid exactly one cycle after acceptance.
        S_RD_CAP: begin
          src_data    <= avm_readdata;
          src_valid   <= 1'b1;
          src_ptr_reg <= src_ptr_reg + 1'b1;  // wraps modulo 2^ADDR_W
          state_reg   <= S_RD_HOLD;
        end

        // src_valid is always high here, so src_ready alone completes the
        // handshake. src_data is not touched until that happens.
        S_RD_HOLD: begin
          if (src_ready) begin
            src_valid <= 1'b0;
            if (word_cnt_reg == LAST_WORD) begin
              // Whole block has been read, so now collect the core's results.
              word_cnt_reg <= '0;
              snk_ready    <= 1'b1;
              state_reg    <= S_WR_IN;
            end else begin
              word_cnt_reg   <= word_cnt_reg + 1'b1;
              avm_address    <= src_ptr_reg;
              avm_read       <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_byteenable <= '1;
              state_reg      <= S_RD_REQ;
            end
          end
        end

        S_WR_IN: begin
          if (snk_valid) begin
            avm_writedata   <= snk_data;
            snk_ready       <= 1'b0;
            avm_address     <= dst_ptr_reg;
            avm_write       <= 1'b1;
            avm_debugaccess <= 1'b1;
            avm_chipselect  <= 1'b1;
            avm_byteenable  <= '1;
            state_reg       <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (!avm_waitrequest) begin
            avm_write       <= 1'b0;
            avm_debugaccess <= 1'b0;
            avm_chipselect  <= 1'b0;
            avm_byteenable  <= '0;
            dst_ptr_reg     <= dst_ptr_reg + 1'b1;
            if (word_cnt_reg == LAST_WORD) begin
              word_cnt_reg <= '0;
              if (blocks_reg == 8'd1) begin
                done      <= 1'b1;
                state_reg <= S_DONE;
              end else begin
                // Start the next block. src_ptr_reg already points past the
                // last word that was read.
                blocks_reg     <= blocks_reg - 1'b1;
                avm_address    <= src_ptr_reg;
                avm_read       <= 1'b1;
                avm_chipselect <= 1'b1;
                avm_byteenable <= '1;
                state_reg      <= S_RD_REQ;
              end
            end else begin
              word_cnt_reg <= word_cnt_reg + 1'b1;
              snk_ready    <= 1'b1;
              state_reg    <= S_WR_IN;
            end
          end
        end

        // busy stays high for the done cycle itself and drops as DONE exits.
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_mem_block_master.sv
// ---------------------------------------------------------------------------
// tb_chacha_mem_block_master
//
// Behavioural environment for chacha_mem_block_master:
//   - 16K-word memory responder with an optional waitrequest pattern
//   - a stand-in core that XORs every word with KEY, with optional stalls
//   - a reference model that works out, block by block, the access sequence
//     and the final memory image for a command
// ---------------------------------------------------------------------------
module tb_chacha_mem_block_master;

  localparam int AW        = 14;
  localparam int DW        = 32;
  localparam int MEM_WORDS = 1 << AW;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [7:0]    cmd_blocks = '0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_read, avm_write, avm_debugaccess;
  logic [DW-1:0] avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_waitrequest;
  logic [DW-1:0] src_data;
  logic          src_valid, src_ready;
  logic [DW-1:0] snk_data;
  logic          snk_valid, snk_ready;

  chacha_mem_block_master #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_blocks(cmd_blocks),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_debugaccess(avm_debugaccess), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------ models
  logic [DW-1:0] mem      [0:MEM_WORDS-1];
  logic [DW-1:0] init_mem [0:MEM_WORDS-1];
  logic [DW-1:0] ref_mem  [0:MEM_WORDS-1];
  logic [DW-1:0] cbuf     [0:255];
  acc_t act_q[$];
  acc_t exp_q[$];

  bit   stall_en = 0, src_stall_en = 0, snk_stall_en = 0;
  bit   model_clr = 0, fill_req = 0;
  logic [31:0] fill_seed = '0;
  int   acc_cnt = 0, wait_cnt = 0, c_wr = 0, c_rd = 0;
  int   src_hold = 0, snk_hold = 0, proto_err = 0, req_seen = 0;
  logic prev_avm_stall = 0, prev_src_stall = 0, prev_rd = 0, prev_wr = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0, prev_src_data = '0;
  logic snk_hold_on;

  // Every 4th access (counted from 0) is stalled for 3 cycles.
  assign avm_waitrequest = stall_en && (avm_read || avm_write) &&
                           (acc_cnt % 4 == 3) && (wait_cnt < 3);
  // Word 7 of each block is refused for 5 cycles.
  assign src_ready   = !(src_stall_en && (c_wr % 16 == 7) && (src_hold < 5));
  // Result word 3 of each block is withheld for 4 cycles while the DUT waits.
  assign snk_hold_on = snk_stall_en && (c_rd % 16 == 3) && (snk_hold < 4);
  assign snk_valid   = (c_wr != c_rd) && !snk_hold_on;
  assign snk_data    = cbuf[c_rd[7:0]];

  logic [89:0] all_outs;
  assign all_outs = {busy, done, avm_address, avm_chipselect, avm_read, avm_write,
                     avm_writedata, avm_byteenable, avm_debugaccess, src_data,
                     src_valid, snk_ready};

  always @(posedge clk) begin
    int e;
    e = 0;
    if (fill_req)
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= (32'(i) * 32'h9E3779B1) ^ fill_seed;
    if (model_clr) begin
      acc_cnt <= 0; wait_cnt <= 0; c_wr <= 0; c_rd <= 0; src_hold <= 0; snk_hold <= 0;
      proto_err <= 0; req_seen <= 0; prev_avm_stall <= 0; prev_src_stall <= 0;
      act_q.delete();
    end else if (reset_n) begin
      // memory responder
      if (avm_read || avm_write) begin
        req_seen <= req_seen + 1;
        if (avm_waitrequest) wait_cnt <= wait_cnt + 1;
        else begin wait_cnt <= 0; acc_cnt <= acc_cnt + 1; end
      end
      if (avm_read && !avm_waitrequest) begin
        avm_readdata <= mem[avm_address];
        act_q.push_back({1'b0, avm_address, mem[avm_address]});
      end
      if (avm_write && avm_debugaccess && !avm_waitrequest) begin
        mem[avm_address] <= avm_writedata;
        act_q.push_back({1'b1, avm_address, avm_writedata});
      end
      // bus protocol rules
      if (avm_read && avm_write) e++;
      if (avm_chipselect !== (avm_read | avm_write)) e++;
      if (avm_debugaccess !== avm_write) e++;
      if ((avm_read || avm_write) && avm_byteenable !== 4'hF) e++;
      if (prev_avm_stall && (avm_address !== prev_addr || avm_writedata !== prev_wdata ||
                             avm_read !== prev_rd || avm_write !== prev_wr)) e++;
      if (prev_src_stall && (!src_valid || src_data !== prev_src_data)) e++;
      prev_avm_stall <= (avm_read || avm_write) && avm_waitrequest;
      prev_addr      <= avm_address;
      prev_wdata     <= avm_writedata;
      prev_rd        <= avm_read;
      prev_wr        <= avm_write;
      prev_src_stall <= src_valid && !src_ready;
      prev_src_data  <= src_data;
      // core stand-in
      if (src_valid && src_ready) begin
        cbuf[c_wr[7:0]] <= src_data ^ KEY;
        c_wr <= c_wr + 1;
        src_hold <= 0;
      end else if (src_valid) begin
        src_hold <= src_hold + 1;
      end
      if (snk_valid && snk_ready) begin
        c_rd <= c_rd + 1;
        snk_hold <= 0;
      end else if (snk_ready && snk_hold_on) begin
        snk_hold <= snk_hold + 1;
      end
      proto_err <= proto_err + e;
    end else begin
      prev_avm_stall <= 0;
      prev_src_stall <= 0;
    end
  end

  // ------------------------------------------------------- reference model
  // Works block by block: the whole block is read from the reference memory,
  // then each word is transformed and written. This also covers overlapping
  // regions and address wrap.
  task automatic build_expected(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                input int nb);
    logic [DW-1:0] blk [16];
    logic [AW-1:0] a;
    ref_mem = init_mem;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 16; k++) begin
        a = AW'((int'(s) + 16 * b + k) % MEM_WORDS);
        blk[k] = ref_mem[a];
        exp_q.push_back({1'b0, a, blk[k]});
      end
      for (int k = 0; k < 16; k++) begin
        a = AW'((int'(d) + 16 * b + k) % MEM_WORDS);
        ref_mem[a] = blk[k] ^ KEY;
        exp_q.push_back({1'b1, a, blk[k] ^ KEY});
      end
    end
  endtask

  function automatic int count_log_diffs();
    int n = 0;
    int m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (act_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  function automatic int count_mem_diffs();
    int n = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic int count_writes();
    int n = 0;
    foreach (act_q[i]) if (act_q[i].wr) n++;
    return n;
  endfunction

  // ---------------------------------------------------------------- helpers
  int n_checks = 0, n_fail = 0;
  logic [31:0] seed1;

  // Refill memory from a seed and clear every model counter. DUT must be idle.
  task automatic do_clr(input logic [31:0] seed);
    @(negedge clk);
    fill_seed = seed; fill_req = 1; model_clr = 1;
    @(posedge clk); #1;
    fill_req = 0; model_clr = 0;
    init_mem = mem;
  endtask

  task automatic run_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [7:0] nb,
                         input int max_cyc, output int lat, output bit to);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_blocks = nb; cmd_start = 1;
    @(posedge clk); #1;
    cmd_start = 0;
    lat = 1;
    while (!done && lat < max_cyc) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !done;
    $display("cmd src=%h dst=%h blocks=%0d latency=%0d accesses=%0d", s, d, nb, lat, act_q.size());
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    #3;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_basic(input string tag);
    int lat; bit to; int d;
    do_clr(seed1);
    build_expected(14'h0100, 14'h0200, 1);
    run_cmd(14'h0100, 14'h0200, 8'd1, 400, lat, to);
    n_checks++;
    if (to || lat !== 81) begin
      n_fail++; $display("FAIL %s_latency: got %0d (timeout=%0d) want 81", tag, lat, to);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_at_done: got %b want 1", tag, busy); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_after_done: done=%b busy=%b want 0 0", tag, done, busy);
    end
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL %s_access_count: got %0d want %0d", tag, act_q.size(), exp_q.size());
    end
    d = count_log_diffs();
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL %s_access_seq: %0d entries differ, want 0", tag, d); end
    d = count_mem_diffs();
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL %s_memory: %0d words differ, want 0", tag, d); end
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL %s_protocol: %0d violations, want 0", tag, proto_err); end
  endtask

  task automatic test_waitrequest();
    int lat; bit to; int d;
    stall_en = 1;
    do_clr(seed1);
    build_expected(14'h0100, 14'h0200, 1);
    run_cmd(14'h0100, 14'h0200, 8'd1, 400, lat, to);
    stall_en = 0;
    n_checks++;
    if (to || lat !== 105) begin
      n_fail++; $display("FAIL wait_latency: got %0d (timeout=%0d) want 105", lat, to);
    end
    d = count_log_diffs();
    n_checks++;
    if (d !== 0 || act_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL wait_access_seq: %0d differ, size %0d want %0d", d, act_q.size(), exp_q.size());
    end
    d = count_mem_diffs();
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL wait_memory: %0d words differ, want 0", d); end
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL wait_stability: %0d violations, want 0", proto_err); end
  endtask

  task automatic test_flow_stall();
    int lat; bit to; int d;
    logic [AW-1:0] s, t;
    s = AW'($urandom_range(0, MEM_WORDS - 1));
    t = AW'($urandom_range(0, MEM_WORDS - 1));
    src_stall_en = 1; snk_stall_en = 1;
    do_clr($urandom);
    build_expected(s, t, 1);
    fork
      run_cmd(s, t, 8'd1, 400, lat, to);
      begin
        // A second start mid-transfer must be ignored.
        repeat (20) @(negedge clk);
        cmd_start = 1; cmd_src = 14'h0; cmd_blocks = 8'd7;
        @(negedge clk);
        cmd_start = 0;
      end
    join
    src_stall_en = 0; snk_stall_en = 0;
    n_checks++;
    if (to || lat !== 90) begin
      n_fail++; $display("FAIL flow_latency: got %0d (timeout=%0d) want 90", lat, to);
    end
    d = count_log_diffs();
    n_checks++;
    if (d !== 0 || act_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL flow_access_seq: %0d differ, size %0d want %0d", d, act_q.size(), exp_q.size());
    end
    d = count_mem_diffs();
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL flow_memory: %0d words differ, want 0", d); end
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL flow_src_hold: %0d violations, want 0", proto_err); end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flow_ignored_start: busy=%b want 0", busy); end
  endtask

  task automatic test_wrap();
    int lat; bit to; int d;
    do_clr($urandom);
    build_expected(14'h3FF8, 14'h3FF0, 2);
    run_cmd(14'h3FF8, 14'h3FF0, 8'd2, 800, lat, to);
    n_checks++;
    if (to || lat !== 161) begin
      n_fail++; $display("FAIL wrap_latency: got %0d (timeout=%0d) want 161", lat, to);
    end
    n_checks++;
    if (count_writes() !== 32) begin
      n_fail++; $display("FAIL wrap_write_count: got %0d want 32", count_writes());
    end
    d = count_log_diffs();
    n_checks++;
    if (d !== 0 || act_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL wrap_access_seq: %0d differ, size %0d want %0d", d, act_q.size(), exp_q.size());
    end
    d = count_mem_diffs();
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL wrap_memory: %0d words differ, want 0", d); end
  endtask

  task automatic test_zero_blocks();
    int lat; bit to;
    do_clr($urandom);
    run_cmd(14'h0123, 14'h0456, 8'd0, 50, lat, to);
    n_checks++;
    if (to || lat !== 1) begin
      n_fail++; $display("FAIL zero_latency: got %0d (timeout=%0d) want 1", lat, to);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: done=%b want 0", done); end
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (req_seen !== 0) begin
      n_fail++; $display("FAIL zero_no_access: %0d request cycles, want 0", req_seen);
    end
  endtask

  task automatic test_random();
    int lat; bit to; int d; int nb;
    logic [AW-1:0] s, t;
    for (int r = 0; r < 3; r++) begin
      s  = AW'($urandom_range(0, MEM_WORDS - 1));
      t  = AW'($urandom_range(0, MEM_WORDS - 1));
      nb = $urandom_range(1, 3);
      stall_en = 1'($urandom); src_stall_en = 1'($urandom); snk_stall_en = 1'($urandom);
      do_clr($urandom);
      build_expected(s, t, nb);
      run_cmd(s, t, 8'(nb), 2000, lat, to);
      stall_en = 0; src_stall_en = 0; snk_stall_en = 0;
      n_checks++;
      if (to) begin n_fail++; $display("FAIL rand%0d_timeout: no done in %0d cycles", r, lat); end
      d = count_log_diffs();
      n_checks++;
      if (d !== 0 || act_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_access_seq: %0d differ, size %0d want %0d", r, d, act_q.size(), exp_q.size());
      end
      d = count_mem_diffs();
      n_checks++;
      if (d !== 0 || proto_err !== 0) begin
        n_fail++; $display("FAIL rand%0d_memory: %0d words differ, %0d protocol errors, want 0 0", r, d, proto_err);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_clr(seed1);
    @(negedge clk);
    cmd_src = 14'h0100; cmd_dst = 14'h0200; cmd_blocks = 8'd1; cmd_start = 1;
    @(posedge clk); #1;
    cmd_start = 0;
    while (!(avm_write && avm_address == 14'h0205) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 500) begin n_fail++; $display("FAIL rstmid_reach_word5: not reached in %0d cycles", n); end
    #1 reset_n = 0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h want 0", all_outs); end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (mem[14'h0205] !== init_mem[14'h0205] || mem[14'h0204] !== (init_mem[14'h0104] ^ KEY)) begin
      n_fail++;
      $display("FAIL rstmid_dropped_write: w4=%h w5=%h want %h %h", mem[14'h0204], mem[14'h0205],
               init_mem[14'h0104] ^ KEY, init_mem[14'h0205]);
    end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: done=%b want 0", done); end
    @(negedge clk);
    reset_n = 1;
    repeat (2) @(posedge clk);
    test_basic("rstmid_rerun");
  endtask

  initial begin
    seed1 = $urandom;
    test_reset();
    test_basic("basic");
    test_waitrequest();
    test_flow_stall();
    test_wrap();
    test_zero_blocks();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a task ever stops advancing.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
